// File: rtl/ball_sprite.sv
//------------------------------------------------------------------------------
// Module   : ball_sprite
// Brief    : Bouncing ball sprite with SERVE/MOVE control, wall bounce, scoring
//            and paddle-hit reversal. Optional macro BALL_SPRITE_COLLIDE_EN adds
//            a pixel-overlap collision latch that reverses horizontal motion.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ball_sprite #(
  parameter int         WIDTH        = 10,
  parameter int         HEIGHT       = 10,
  parameter logic [1:0] R            = 2'h3,
  parameter logic [1:0] G            = 2'h3,
  parameter logic [1:0] B            = 2'h3,
  parameter int         SCR_W        = 640,
  parameter int         SCR_H        = 480,
  parameter int         X0           = 320,
  parameter int         Y0           = 240,
  parameter int         SPEED        = 2,
  parameter int         SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        frame,
  input  logic        run,
  input  logic        hit_x,
  input  logic        obj_en,
  output logic [10:0] sx,
  output logic [10:0] sy,
  output logic [1:0]  r,
  output logic [1:0]  g,
  output logic [1:0]  b,
  output logic        en,
  output logic        score_l,
  output logic        score_r,
  output logic        serving
);

  typedef enum logic [0:0] {S_SERVE = 1'b0, S_MOVE = 1'b1} state_t;

  localparam logic signed [11:0] c_HW       = 12'(WIDTH / 2);
  localparam logic signed [11:0] c_HH       = 12'(HEIGHT / 2);
  localparam logic signed [11:0] c_XMAX     = 12'(SCR_W - 1);
  localparam logic signed [11:0] c_YMAX     = 12'(SCR_H - 1);
  localparam logic signed [11:0] c_SPD      = 12'(SPEED);
  localparam logic [10:0]        c_X0       = 11'(X0);
  localparam logic [10:0]        c_Y0       = 11'(Y0);
  localparam logic [10:0]        c_YTOP     = 11'(HEIGHT / 2);
  localparam logic [10:0]        c_YBOT     = 11'(SCR_H - 1 - HEIGHT / 2);
  localparam logic [7:0]         c_CNT_LAST = 8'(SERVE_FRAMES - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [10:0] r_sx, w_sx_nxt;
  logic [10:0] r_sy, w_sy_nxt;
  logic        r_dx, w_dx_nxt;   // 1 = +1, 0 = -1
  logic        r_dy, w_dy_nxt;
  logic        r_pend, w_pend_nxt;
  logic        r_en, r_score_l, r_score_r;
  logic [1:0]  r_r, r_g, r_b;
  logic        w_score_l, w_score_r;
  logic        w_tick, w_win, w_coll, w_rev, w_dx_eff;
  logic signed [11:0] w_px, w_py, w_cx, w_cy, w_mx, w_my;

  assign w_px = $signed({1'b0, x});
  assign w_py = $signed({1'b0, y});
  assign w_cx = $signed({1'b0, r_sx});
  assign w_cy = $signed({1'b0, r_sy});

  assign w_win = (w_px >= w_cx - c_HW) && (w_px < w_cx + c_HW) &&
                 (w_py >= w_cy - c_HH) && (w_py < w_cy + c_HH);

  assign w_tick   = frame & run;
  assign w_rev    = r_pend | hit_x | w_coll;
  assign w_dx_eff = r_dx ^ w_rev;
  assign w_mx     = w_cx + (w_dx_eff ? c_SPD : -c_SPD);
  assign w_my     = w_cy + (r_dy ? c_SPD : -c_SPD);

`ifdef BALL_SPRITE_COLLIDE_EN
  logic r_coll;

  // Overlap seen during the frame being drawn; consumed by the next frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll <= 1'b0;
    end else if (w_tick) begin
      r_coll <= 1'b0;
    end else if (w_win && obj_en) begin
      r_coll <= 1'b1;
    end
  end

  assign w_coll = r_coll;
`else
  logic w_unused_obj_en;
  assign w_unused_obj_en = obj_en;
  assign w_coll          = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sx_nxt    = r_sx;
    w_sy_nxt    = r_sy;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_pend_nxt  = r_pend;
    w_score_l   = 1'b0;
    w_score_r   = 1'b0;
    if (run && hit_x) begin
      w_pend_nxt = 1'b1;
    end
    case (r_state)
      S_SERVE: begin
        if (w_tick) begin
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_MOVE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      S_MOVE: begin
        if (w_tick) begin
          w_pend_nxt = 1'b0;
          w_dx_nxt   = w_dx_eff;
          if ((w_mx - c_HW < 12'sd0) || (w_mx + c_HW > c_XMAX)) begin
            // Ball left the playfield: the opposite side scores and re-serves.
            w_score_r   = (w_mx - c_HW < 12'sd0);
            w_score_l   = ~(w_mx - c_HW < 12'sd0);
            w_sx_nxt    = c_X0;
            w_sy_nxt    = c_Y0;
            w_dx_nxt    = ~w_dx_eff;
            w_state_nxt = S_SERVE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_sx_nxt = w_mx[10:0];
            if (w_my - c_HH < 12'sd0) begin
              w_sy_nxt = c_YTOP;
              w_dy_nxt = 1'b1;
            end else if (w_my + c_HH > c_YMAX) begin
              w_sy_nxt = c_YBOT;
              w_dy_nxt = 1'b0;
            end else begin
              w_sy_nxt = w_my[10:0];
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_SERVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_SERVE;
      r_cnt     <= 8'd0;
      r_sx      <= c_X0;
      r_sy      <= c_Y0;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_pend    <= 1'b0;
      r_en      <= 1'b0;
      r_r       <= 2'd0;
      r_g       <= 2'd0;
      r_b       <= 2'd0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sx      <= w_sx_nxt;
      r_sy      <= w_sy_nxt;
      r_dx      <= w_dx_nxt;
      r_dy      <= w_dy_nxt;
      r_pend    <= w_pend_nxt;
      r_en      <= w_win;
      r_r       <= w_win ? R : 2'd0;
      r_g       <= w_win ? G : 2'd0;
      r_b       <= w_win ? B : 2'd0;
      r_score_l <= w_score_l;
      r_score_r <= w_score_r;
    end
  end

  assign sx      = r_sx;
  assign sy      = r_sy;
  assign en      = r_en;
  assign r       = r_r;
  assign g       = r_g;
  assign b       = r_b;
  assign score_l = r_score_l;
  assign score_r = r_score_r;
  assign serving = (r_state == S_SERVE);

endmodule

`default_nettype wire

// File: tb/tb_ball_sprite.sv
//------------------------------------------------------------------------------
// Module   : tb_ball_sprite
// Brief    : Scoreboard bench for ball_sprite driving the ball along a
//            hand-computed trajectory (serve, bounces, scoring, hits, reset).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ball_sprite;

  localparam int c_SX = 0, c_SY = 1, c_SERV = 2, c_EN = 3, c_RGB = 4, c_SCL = 5, c_SCR = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst, frame, run, hit_x, obj_en;
  logic [10:0] x, y, sx, sy;
  logic [1:0]  r, g, b;
  logic        en, score_l, score_r, serving;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ball_sprite dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame(frame), .run(run),
    .hit_x(hit_x), .obj_en(obj_en), .sx(sx), .sy(sy), .r(r), .g(g), .b(b),
    .en(en), .score_l(score_l), .score_r(score_r), .serving(serving)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic logic [31:0] dut_val(input int sel);
    logic [31:0] v;
    v = '1;
    case (sel)
      c_SX:   v = 32'(sx);
      c_SY:   v = 32'(sy);
      c_SERV: v = 32'(serving);
      c_EN:   v = 32'(en);
      c_RGB:  v = 32'({r, g, b});
      c_SCL:  v = 32'(score_l);
      c_SCR:  v = 32'(score_r);
      default: v = '1;
    endcase
    return v;
  endfunction

  task automatic expect_eq(input string nm, input int sel, input int val);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = 32'(val);
    exp_q.push_back(e);
  endtask

  // Monitor: compares each expectation against the live DUT outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      wait (exp_q.size() != 0);
      e   = exp_q.pop_front();
      act = dut_val(e.sel);
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic frame_pulse(input logic hit);
    frame = 1'b1;
    hit_x = hit;
    @(negedge clk);
    frame = 1'b0;
    hit_x = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_pulse(1'b0);
  endtask

  task automatic pix(input int xx, input int yy, input int exp_en);
    x = 11'(xx);
    y = 11'(yy);
    @(negedge clk);
    expect_eq("pix_en", c_EN, exp_en);
    expect_eq("pix_rgb", c_RGB, exp_en ? 63 : 0);
  endtask

  task automatic pos(input string nm, input int ex, input int ey);
    expect_eq({nm, "_sx"}, c_SX, ex);
    expect_eq({nm, "_sy"}, c_SY, ey);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b1; frame = 1'b0; hit_x = 1'b0; obj_en = 1'b0;
    x = 11'd0; y = 11'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pos("reset", 320, 240);
    expect_eq("reset_serving", c_SERV, 1);
    expect_eq("reset_en", c_EN, 0);
    expect_eq("reset_rgb", c_RGB, 0);
    expect_eq("reset_score_l", c_SCL, 0);
    expect_eq("reset_score_r", c_SCR, 0);

    // Window is 315<=x<325, 235<=y<245 around (320,240).
    pix(315, 235, 1);
    pix(324, 244, 1);
    pix(325, 235, 0);
    pix(315, 234, 0);
    pix(314, 240, 0);
    pix(320, 245, 0);
    x = 11'd0; y = 11'd0;
    @(negedge clk);

    frames(59);
    expect_eq("serve_59", c_SERV, 1);
    run = 1'b0;
    frames(3);
    expect_eq("serve_frozen", c_SERV, 1);
    run = 1'b1;
    frames(1);
    expect_eq("serve_done", c_SERV, 0);
    pos("serve_done", 320, 240);
    frames(1);
    pos("move1", 322, 242);

    frames(116);
    pos("move117", 554, 474);
    frames(1);
    pos("bottom_clamp", 556, 474);
    frames(1);
    pos("bottom_up", 558, 472);

    frames(38);
    pos("move157", 634, 396);
    frames(1);
    expect_eq("right_score_l", c_SCL, 1);
    expect_eq("right_score_r", c_SCR, 0);
    expect_eq("right_serving", c_SERV, 1);
    pos("right_reload", 320, 240);
    @(negedge clk);
    expect_eq("score_l_one_cycle", c_SCL, 0);

    frames(59);
    expect_eq("serve2_59", c_SERV, 1);
    frames(1);
    expect_eq("serve2_done", c_SERV, 0);
    frames(110);
    pos("left110", 100, 20);
    frame_pulse(1'b1);
    pos("hit_coincident", 102, 18);
    run = 1'b0;
    frame_pulse(1'b1);
    pos("hit_run0", 102, 18);
    expect_eq("hit_run0_serving", c_SERV, 0);
    run = 1'b1;
    frame_pulse(1'b1);
    pos("hit_run1", 100, 16);
    frames(1);
    pos("after_hit", 98, 14);

    hit_x = 1'b1;
    @(negedge clk);
    hit_x = 1'b0;
    expect_eq("pending_no_move", c_SX, 98);
    frames(1);
    pos("pending_applied", 100, 12);
    frames(1);
    pos("pending_cleared", 102, 10);
    frames(2);
    pos("near_top", 106, 6);
    frames(1);
    pos("top_clamp", 108, 5);
    frames(1);
    pos("top_down", 110, 7);

    frame_pulse(1'b1);
    pos("turn_left", 108, 9);
    frames(51);
    pos("left_edge", 6, 111);
    frames(1);
    expect_eq("left_score_r", c_SCR, 1);
    expect_eq("left_score_l", c_SCL, 0);
    expect_eq("left_serving", c_SERV, 1);
    pos("left_reload", 320, 240);
    @(negedge clk);
    expect_eq("score_r_one_cycle", c_SCR, 0);

    frames(60);
    expect_eq("serve3_done", c_SERV, 0);
    frames(1);
    pos("serve3_move", 322, 242);
    pix(322, 242, 1);

    // Async reset with the clock held low.
    clk_run = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    pos("async_rst", 320, 240);
    expect_eq("async_rst_serving", c_SERV, 1);
    expect_eq("async_rst_en", c_EN, 0);
    expect_eq("async_rst_rgb", c_RGB, 0);
    #1;
    rst = 1'b0;
    clk_run = 1'b1;
    #20;

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
